// File: rtl/blink_delay_ctrl.sv
// Blink-delay register with key, Avalon-MM and auto-sweep sources of change.
// Optional interrupt support is enabled with `define BLINK_DELAY_CTRL_IRQ_EN.
module blink_delay_ctrl #(
    parameter int          DELAY_W   = 4,
    parameter int          DELAY_RST = 8,
    parameter int          DELAY_MIN = 0,
    parameter int          DELAY_MAX = 15,
    parameter logic [31:0] SWEEP_RST = 32'd50000000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               slower,
    input  logic               faster,
    input  logic [1:0]         avs_address,
    input  logic               avs_read,
    input  logic               avs_write,
    input  logic [31:0]        avs_writedata,
    output logic [31:0]        avs_readdata,
    output logic [DELAY_W-1:0] delay,
    output logic               sweeping
`ifdef BLINK_DELAY_CTRL_IRQ_EN
    ,
    output logic               irq
`endif
);

    localparam logic [DELAY_W-1:0] D_MIN = DELAY_W'(DELAY_MIN);
    localparam logic [DELAY_W-1:0] D_MAX = DELAY_W'(DELAY_MAX);
    localparam logic [DELAY_W-1:0] D_RST = DELAY_W'(DELAY_RST);
    localparam logic signed [33:0] S_MIN = 34'(DELAY_MIN);
    localparam logic signed [33:0] S_MAX = 34'(DELAY_MAX);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_UP   = 2'd1,
        S_DOWN = 2'd2
    } sweep_state_t;

    sweep_state_t state_q, state_d;

    logic [31:0] tick_q, tick_d;
    logic [31:0] sweep_period;
    logic [31:0] tick_last;
    logic [15:0] evcnt;
    logic        sweep_en;
    logic        key_lock;

    logic        wr_delay, wr_ctrl, wr_evcnt, wr_period;
    logic        step, step_up;
    logic        key_try, key_apply;
    logic [DELAY_W-1:0] delay_d;
    logic [31:0] ctrl_rd;
    logic [31:0] rd_mux;

`ifdef BLINK_DELAY_CTRL_IRQ_EN
    logic irq_en;
    logic irq_pend;
    logic irq_set;
`endif

    // Saturate a 32-bit write value into the legal delay range.
    function automatic logic [DELAY_W-1:0] sat_delay(input logic [31:0] v);
        logic signed [33:0] vs;
        vs = $signed({2'b00, v});
        if (vs > S_MAX)
            sat_delay = D_MAX;
        else if (vs < S_MIN)
            sat_delay = D_MIN;
        else
            sat_delay = v[DELAY_W-1:0];
    endfunction

    assign wr_delay  = avs_write && (avs_address == 2'd0);
    assign wr_ctrl   = avs_write && (avs_address == 2'd1);
    assign wr_evcnt  = avs_write && (avs_address == 2'd2);
    assign wr_period = avs_write && (avs_address == 2'd3);

    // A period of zero steps every cycle, same as a period of one.
    assign tick_last = (sweep_period == 32'd0) ? 32'd0 : sweep_period - 32'd1;
    assign sweeping  = (state_q != S_IDLE);

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        step    = 1'b0;
        step_up = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (sweep_en) begin
                    state_d = S_UP;
                    tick_d  = '0;
                end
            end
            S_UP, S_DOWN: begin
                if (!sweep_en) begin
                    state_d = S_IDLE;
                    tick_d  = '0;
                end else if (tick_q >= tick_last) begin
                    tick_d = '0;
                    step   = 1'b1;
                    if (state_q == S_UP) begin
                        if (delay == D_MAX) begin
                            step_up = 1'b0;
                            state_d = S_DOWN;
                        end else begin
                            step_up = 1'b1;
                            if (delay + 1'b1 == D_MAX)
                                state_d = S_DOWN;
                        end
                    end else begin
                        if (delay == D_MIN) begin
                            step_up = 1'b1;
                            state_d = S_UP;
                        end else begin
                            step_up = 1'b0;
                            if (delay - 1'b1 == D_MIN)
                                state_d = S_UP;
                        end
                    end
                end else begin
                    tick_d = tick_q + 32'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A CPU write replaces the step; the sweep keeps its direction.
        if (wr_delay && step)
            state_d = state_q;
        if (wr_period)
            tick_d = '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
        end
    end

    assign key_try   = !key_lock && !sweeping && (slower ^ faster) && !wr_delay;
    assign key_apply = key_try && (slower ? (delay != D_MAX) : (delay != D_MIN));

    always_comb begin
        delay_d = delay;
        if (wr_delay)
            delay_d = sat_delay(avs_writedata);
        else if (step)
            delay_d = step_up ? delay + 1'b1 : delay - 1'b1;
        else if (key_apply)
            delay_d = slower ? delay + 1'b1 : delay - 1'b1;
    end

`ifdef BLINK_DELAY_CTRL_IRQ_EN
    // Refusals: a key blocked at a bound, or a sweep step that has to reverse.
    assign irq_set = (key_try && !key_apply)
                   || (step && !wr_delay &&
                       (((state_q == S_UP) && (delay == D_MAX)) ||
                        ((state_q == S_DOWN) && (delay == D_MIN))));
    assign ctrl_rd = {28'd0, irq_pend, irq_en, key_lock, sweep_en};
`else
    assign ctrl_rd = {30'd0, key_lock, sweep_en};
`endif

    always_comb begin
        rd_mux = '0;
        unique case (avs_address)
            2'd0: rd_mux = 32'(delay);
            2'd1: rd_mux = ctrl_rd;
            2'd2: rd_mux = 32'(evcnt);
            2'd3: rd_mux = sweep_period;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            delay        <= D_RST;
            avs_readdata <= '0;
            sweep_en     <= 1'b0;
            key_lock     <= 1'b0;
            evcnt        <= '0;
            sweep_period <= SWEEP_RST;
        end else begin
            delay <= delay_d;
            if (avs_read)
                avs_readdata <= rd_mux;
            if (wr_ctrl) begin
                sweep_en <= avs_writedata[0];
                key_lock <= avs_writedata[1];
            end
            if (wr_evcnt)
                evcnt <= '0;
            else if (key_apply && (evcnt != 16'hFFFF))
                evcnt <= evcnt + 16'd1;
            if (wr_period)
                sweep_period <= avs_writedata;
        end
    end

`ifdef BLINK_DELAY_CTRL_IRQ_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en   <= 1'b0;
            irq_pend <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (wr_ctrl)
                irq_en <= avs_writedata[2];
            if (irq_set)
                irq_pend <= 1'b1;
            else if (wr_ctrl && avs_writedata[3])
                irq_pend <= 1'b0;
            irq <= irq_pend & irq_en;
        end
    end
`endif

endmodule

// File: tb/tb_blink_delay_ctrl.sv
// Scoreboard bench for blink_delay_ctrl: reads are queued with expected data
// and checked by an independent monitor one cycle after the read strobe.
module tb_blink_delay_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        slower, faster;
    logic [1:0]  avs_address;
    logic        avs_read, avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic [3:0]  delay;
    logic        sweeping;
`ifdef BLINK_DELAY_CTRL_IRQ_EN
    logic        irq;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] exp;
        string       name;
    } rd_t;
    rd_t rdq[$];

    int sw_exp[11] = '{13, 13, 14, 14, 15, 15, 14, 14, 13, 13, 12};

    always #5 clk = ~clk;

    blink_delay_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .slower       (slower),
        .faster       (faster),
        .avs_address  (avs_address),
        .avs_read     (avs_read),
        .avs_write    (avs_write),
        .avs_writedata(avs_writedata),
        .avs_readdata (avs_readdata),
        .delay        (delay),
        .sweeping     (sweeping)
`ifdef BLINK_DELAY_CTRL_IRQ_EN
        ,
        .irq          (irq)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic avs_wr(input logic [1:0] a, input logic [31:0] d);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        @(negedge clk);
        avs_write = 1'b0;
    endtask

    task automatic avs_rd(input logic [1:0] a, input logic [31:0] exp, input string name);
        rd_t e;
        e.exp  = exp;
        e.name = name;
        rdq.push_back(e);
        avs_address = a;
        avs_read    = 1'b1;
        @(negedge clk);
        avs_read = 1'b0;
    endtask

    task automatic avs_rw(input logic [1:0] a, input logic [31:0] d, input logic [31:0] exp,
                          input string name);
        rd_t e;
        e.exp  = exp;
        e.name = name;
        rdq.push_back(e);
        avs_address   = a;
        avs_writedata = d;
        avs_read      = 1'b1;
        avs_write     = 1'b1;
        @(negedge clk);
        avs_read  = 1'b0;
        avs_write = 1'b0;
    endtask

    task automatic key(input logic s, input logic f);
        slower = s;
        faster = f;
        @(negedge clk);
        slower = 1'b0;
        faster = 1'b0;
    endtask

    // Read monitor: a strobe seen at an edge must produce data right after it.
    initial begin
        logic rd_seen;
        rd_t  e;
        forever begin
            @(posedge clk);
            rd_seen = avs_read && reset_n;
            #1;
            if (rd_seen) begin
                if (rdq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_read: got 0x%0h, expected no read", avs_readdata);
                end else begin
                    e = rdq.pop_front();
                    chk(e.name, avs_readdata, e.exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected end of stimulus");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n       = 1'b0;
        slower        = 1'b0;
        faster        = 1'b0;
        avs_address   = 2'd0;
        avs_read      = 1'b0;
        avs_write     = 1'b0;
        avs_writedata = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_delay", 32'(delay), 32'd8);
        chk("rst_sweeping", 32'(sweeping), 32'd0);
        chk("rst_readdata", avs_readdata, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        avs_rd(2'd0, 32'd8, "rd_delay_rst");
        avs_rd(2'd1, 32'd0, "rd_ctrl_rst");
        avs_rd(2'd2, 32'd0, "rd_evcnt_rst");
        avs_rd(2'd3, 32'd50000000, "rd_period_rst");
        @(negedge clk);
        chk("rd_hold", avs_readdata, 32'd50000000);

        for (int i = 0; i < 10; i++) begin
            key(1'b1, 1'b0);
            chk("slower_delay", 32'(delay), (i < 7) ? 32'(9 + i) : 32'd15);
        end
        avs_rd(2'd2, 32'd7, "evcnt_after_slower");
        key(1'b1, 1'b1);
        chk("both_keys_delay", 32'(delay), 32'd15);
        avs_rd(2'd2, 32'd7, "evcnt_after_both");

        avs_address   = 2'd0;
        avs_writedata = 32'd3;
        avs_write     = 1'b1;
        faster        = 1'b1;
        @(negedge clk);
        avs_write = 1'b0;
        faster    = 1'b0;
        chk("write_beats_key", 32'(delay), 32'd3);
        avs_rd(2'd2, 32'd7, "evcnt_key_dropped");
        avs_wr(2'd0, 32'h1F);
        avs_rd(2'd0, 32'd15, "delay_clamp_hi");
        avs_rw(2'd0, 32'd5, 32'd15, "rw_same_cycle_old");
        avs_rd(2'd0, 32'd5, "delay_after_rw");

        avs_wr(2'd0, 32'd0);
        key(1'b0, 1'b1);
        chk("faster_at_min", 32'(delay), 32'd0);
        key(1'b1, 1'b0);
        chk("slower_from_min", 32'(delay), 32'd1);
        avs_rd(2'd2, 32'd8, "evcnt_bound");

        avs_wr(2'd1, 32'd2);
        repeat (4) key(1'b0, 1'b1);
        chk("key_lock_delay", 32'(delay), 32'd1);
        avs_rd(2'd1, 32'd2, "ctrl_key_lock");
        avs_rd(2'd2, 32'd8, "evcnt_locked");
        avs_wr(2'd2, 32'hDEAD);
        avs_rd(2'd2, 32'd0, "evcnt_cleared");
        avs_wr(2'd1, 32'd0);

        avs_wr(2'd3, 32'd2);
        avs_wr(2'd0, 32'd13);
        avs_wr(2'd1, 32'd1);
        chk("sweep_start_idle", 32'(sweeping), 32'd0);
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            chk("sweep_delay", 32'(delay), 32'(sw_exp[i]));
            chk("sweep_flag", 32'(sweeping), 32'd1);
        end
        avs_wr(2'd1, 32'd0);
        chk("sweep_stop_lag", 32'(sweeping), 32'd1);
        chk("sweep_stop_delay", 32'(delay), 32'd12);
        @(negedge clk);
        chk("sweep_stopped", 32'(sweeping), 32'd0);
        repeat (3) @(negedge clk);
        chk("sweep_hold_delay", 32'(delay), 32'd12);

`ifdef BLINK_DELAY_CTRL_IRQ_EN
        avs_wr(2'd1, 32'd8);
        avs_wr(2'd1, 32'd4);
        chk("irq_idle", 32'(irq), 32'd0);
        avs_wr(2'd0, 32'd0);
        key(1'b0, 1'b1);
        chk("irq_lag", 32'(irq), 32'd0);
        chk("irq_delay_min", 32'(delay), 32'd0);
        @(negedge clk);
        chk("irq_set", 32'(irq), 32'd1);
        avs_rd(2'd1, 32'hC, "ctrl_irq_pend");
        avs_wr(2'd1, 32'hC);
        @(negedge clk);
        chk("irq_cleared", 32'(irq), 32'd0);
        avs_wr(2'd1, 32'd0);
`else
        avs_wr(2'd1, 32'hFFFF_FFFF);
        avs_rd(2'd1, 32'd3, "ctrl_upper_bits");
        avs_wr(2'd1, 32'd0);
`endif

        avs_wr(2'd1, 32'd1);
        repeat (6) @(negedge clk);
        avs_rd(2'd3, 32'd2, "period_before_reset");
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_delay", 32'(delay), 32'd8);
        chk("async_rst_sweeping", 32'(sweeping), 32'd0);
        chk("async_rst_readdata", avs_readdata, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        avs_rd(2'd1, 32'd0, "ctrl_after_rst");
        avs_rd(2'd3, 32'd50000000, "period_after_rst");
        avs_rd(2'd2, 32'd0, "evcnt_after_rst");
        avs_rd(2'd0, 32'd8, "delay_after_rst");
        chk("sweeping_after_rst", 32'(sweeping), 32'd0);

        for (int k = 0; k < 10 && rdq.size() > 0; k++)
            @(negedge clk);
        if (rdq.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL read_drain: got %0d reads outstanding, expected 0", rdq.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
